nbdcache_vldrty_array: RTL and testbench
========================================

Name: nbdcache_vldrty_array

Overview:
- Parametrised successor to the byte-aligned valid/dirty SRAM of the non-blocking L1 dcache.
- Stores per-set, per-way valid/dirty bits in flops, without the 4x byte-enable overhead.
- Arbitrates NR_PORTS requesters (port 0 = miss handler, higher = cache controllers) and maintains a live dirty-line counter.
- Includes a hardware invalidate-all sweep used after reset and on demand (fence.i / flush), replacing software-driven line-by-line invalidation.

Parameters:
- NR_PORTS, 4, number of requesting ports; lower index has higher priority.
- NUM_SETS, 256, number of sets; power of two, at least 2.
- SET_ASSOC, 8, number of ways.
- IDX_W, $clog2(NUM_SETS), set-index width.
- CNT_W, $clog2(NUM_SETS*SET_ASSOC+1), dirty-counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- req_i  in  NR_PORTS  per-port access request.
- gnt_o  out  NR_PORTS  one-hot grant, same cycle as the request.
- we_i  in  NR_PORTS  per-port write enable.
- set_i  in  NR_PORTS*IDX_W  per-port set index.
- way_be_i  in  NR_PORTS*SET_ASSOC  per-port way write mask.
- valid_wdata_i  in  NR_PORTS  valid bit to write, broadcast to all masked ways.
- dirty_wdata_i  in  NR_PORTS  dirty bit to write, broadcast to all masked ways.
- rvalid_o  out  1  read data valid, one cycle after a grant.
- valid_rdata_o  out  SET_ASSOC  valid bits of the set granted in the previous cycle.
- dirty_rdata_o  out  SET_ASSOC  dirty bits of the set granted in the previous cycle.
- invalidate_i  in  1  start invalidate-all sweep; level, sampled in IDLE.
- busy_o  out  1  sweep in progress.
- done_o  out  1  single-cycle pulse when a sweep completes.
- dirty_count_o  out  CNT_W  number of (valid & dirty) way entries.
- dirty_any_o  out  1  dirty_count_o != 0.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous, active-high.
- Reset values (cycle after rst_i):
  - state = SWEEP, sweep pointer = 0.
  - busy_o = 1, gnt_o = 0, rvalid_o = 0, done_o = 0, dirty_count_o = 0.
  - valid_rdata_o and dirty_rdata_o = 0.
  - The bit array itself is not reset; it is cleared by the sweep.
- FSM states: SWEEP, IDLE.
  - SWEEP: each cycle clear all valid/dirty bits of set ptr, then ptr++. After set NUM_SETS-1, go to IDLE.
  - SWEEP duration is exactly NUM_SETS cycles. done_o pulses in the first IDLE cycle.
  - During SWEEP, gnt_o = 0 and requests are ignored; requesters hold req_i.
  - IDLE with invalidate_i = 1: enter SWEEP next cycle. No grant that cycle (invalidate beats requests).
  - dirty_count_o is forced to 0 on the cycle SWEEP is entered.
  - invalidate_i during SWEEP: ignored, not queued.
- Arbitration (IDLE, invalidate_i = 0):
  - gnt_o is combinational from req_i: one-hot to the lowest-index requester, no fairness.
  - A request is accepted in the cycle it is granted.
- Read:
  - Every grant (read or write) registers the granted set.
  - Next cycle: rvalid_o = 1 and rdata reflects the array contents before any write performed in the grant cycle (read-before-write).
  - Without a grant in the previous cycle: rvalid_o = 0, rdata holds its last value.
- Write (we_i of the granted port):
  - For each way w with way_be_i[w] = 1: valid <= valid_wdata_i, dirty <= dirty_wdata_i, taking effect at the clock edge.
  - way_be_i = 0 with we_i = 1: legal no-op write; still returns rvalid_o.
- Dirty counter:
  - delta = popcount(new v&d over masked ways) - popcount(old v&d over masked ways). Range -SET_ASSOC..+SET_ASSOC; compute in CNT_W+1 signed.
  - Saturation never occurs; assert 0 <= count <= NUM_SETS*SET_ASSOC.
- Mid-sweep reset: restarts the sweep at set 0 with full duration. No done_o for the aborted sweep.

Decomposition:
- Package nbdcache_vldrty_pkg:
  - state enum {SWEEP, IDLE}.
  - vldrty_way_t struct {valid, dirty}.
  - Function popcount_vd(mask, valid, dirty).
- Sub-module nbdcache_vldrty_arb: fixed-priority one-hot arbiter plus grant-index encoder, parametrised by NR_PORTS.
- Everything else stays in one module.

Test Plan (NR_PORTS = 4, NUM_SETS = 256, SET_ASSOC = 8):
- rst_i high for 1 cycle, then low: busy_o = 1 for 256 cycles, gnt_o = 0 throughout, done_o pulses once at cycle 257, dirty_count_o = 0.
- Port 2 writes set 5, way_be = 8'h0C, v = 1, d = 1: gnt_o = 4'b0100, dirty_count_o = 2. A later read of set 5 gives valid_rdata_o = 8'h0C, dirty_rdata_o = 8'h0C, with rvalid_o one cycle after the grant.
- Ports 0 and 3 request simultaneously: gnt_o = 4'b0001. Port 3 (holding req) is granted 4'b1000 the next cycle.
- Port 1 writes set 5, way_be = 8'h04, v = 1, d = 0: rdata the next cycle still shows dirty 8'h0C (read-before-write), dirty_count_o = 1. A subsequent read shows dirty 8'h08.
- invalidate_i together with req_i[1] in IDLE: no grant, 256-cycle sweep, dirty_count_o = 0 and dirty_any_o = 0 from the first sweep cycle. Afterwards, reads of set 5 return 0/0.
- rst_i asserted while the sweep pointer = 100: no done_o, sweep restarts at set 0, done_o 257 cycles after rst_i deasserts.

Source files
------------

// File: rtl/nbdcache_vldrty_pkg.sv
// Shared types and helpers for the dcache valid/dirty flop array.
package nbdcache_vldrty_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_e;

  typedef struct packed {
    logic valid;
    logic dirty;
  } vldrty_way_t;

  // popcount_vd works on a fixed-width vector; callers zero-extend, so SET_ASSOC must not exceed this.
  localparam int VD_MAX_WAYS = 32;
  localparam int VD_CNT_W    = 6;

  function automatic logic [VD_CNT_W-1:0] popcount_vd(input logic [VD_MAX_WAYS-1:0] mask,
                                                      input logic [VD_MAX_WAYS-1:0] valid,
                                                      input logic [VD_MAX_WAYS-1:0] dirty);
    logic [VD_CNT_W-1:0] cnt;
    cnt = '0;
    for (int w = 0; w < VD_MAX_WAYS; w++) begin
      cnt = cnt + VD_CNT_W'(mask[w] & valid[w] & dirty[w]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/nbdcache_vldrty_arb.sv
// Fixed-priority arbiter: one-hot grant to the lowest-index requester plus its encoded index.
module nbdcache_vldrty_arb #(
  parameter int NR_PORTS = 4,
  parameter int PORT_W   = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
  input  logic [NR_PORTS-1:0] req,
  output logic [NR_PORTS-1:0] gnt,
  output logic [PORT_W-1:0]   idx,
  output logic                any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // Walk from the top so the lowest-index requester overwrites last.
    for (int i = NR_PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = PORT_W'(i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nbdcache_vldrty_array.sv
// Per-set/per-way valid+dirty flop array with port arbitration, invalidate-all sweep
// and a live count of valid&dirty entries.
module nbdcache_vldrty_array
  import nbdcache_vldrty_pkg::*;
#(
  parameter int NR_PORTS  = 4,
  parameter int NUM_SETS  = 256,
  parameter int SET_ASSOC = 8,
  parameter int IDX_W     = $clog2(NUM_SETS),
  parameter int CNT_W     = $clog2(NUM_SETS * SET_ASSOC + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NR_PORTS-1:0]           req_i,
  output logic [NR_PORTS-1:0]           gnt_o,
  input  logic [NR_PORTS-1:0]           we_i,
  input  logic [NR_PORTS*IDX_W-1:0]     set_i,
  input  logic [NR_PORTS*SET_ASSOC-1:0] way_be_i,
  input  logic [NR_PORTS-1:0]           valid_wdata_i,
  input  logic [NR_PORTS-1:0]           dirty_wdata_i,
  output logic                          rvalid_o,
  output logic [SET_ASSOC-1:0]          valid_rdata_o,
  output logic [SET_ASSOC-1:0]          dirty_rdata_o,
  input  logic                          invalidate_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [CNT_W-1:0]              dirty_count_o,
  output logic                          dirty_any_o,
  output logic                          state_o
);

  localparam int PORT_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam logic signed [CNT_W:0] MAX_CNT = (CNT_W + 1)'(NUM_SETS * SET_ASSOC);

  state_e                       state_q, state_d;
  logic [IDX_W-1:0]             ptr_q;
  vldrty_way_t [SET_ASSOC-1:0]  arr_q [NUM_SETS];
  logic [CNT_W-1:0]             count_q;

  logic [NR_PORTS-1:0]          req_eff;
  logic [PORT_W-1:0]            gnt_idx;
  logic                         gnt_any, sweep_start;
  logic [IDX_W-1:0]             sel_set;
  logic [SET_ASSOC-1:0]         sel_be, cur_valid, cur_dirty;
  logic                         sel_we, sel_v, sel_d, wr_en;
  logic [VD_MAX_WAYS-1:0]       be_x, v_x, d_x, wv_x, wd_x;
  logic [VD_CNT_W-1:0]          pc_old, pc_new;
  logic signed [CNT_W:0]        delta, count_next;

  // Requests only reach the arbiter in IDLE without a pending invalidate.
  always_comb begin
    state_d     = state_q;
    sweep_start = 1'b0;
    req_eff     = '0;
    case (state_q)
      SWEEP: if (ptr_q == IDX_W'(NUM_SETS - 1)) state_d = IDLE;
      IDLE: begin
        if (invalidate_i) begin
          state_d     = SWEEP;
          sweep_start = 1'b1;
        end else begin
          req_eff = req_i;
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  nbdcache_vldrty_arb #(
    .NR_PORTS (NR_PORTS),
    .PORT_W   (PORT_W)
  ) u_arb (
    .req (req_eff),
    .gnt (gnt_o),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    sel_set = set_i[gnt_idx*IDX_W +: IDX_W];
    sel_be  = way_be_i[gnt_idx*SET_ASSOC +: SET_ASSOC];
    sel_we  = we_i[gnt_idx];
    sel_v   = valid_wdata_i[gnt_idx];
    sel_d   = dirty_wdata_i[gnt_idx];
    wr_en   = gnt_any & sel_we;
    for (int w = 0; w < SET_ASSOC; w++) begin
      cur_valid[w] = arr_q[sel_set][w].valid;
      cur_dirty[w] = arr_q[sel_set][w].dirty;
    end
  end

  // Counter delta only looks at the masked ways: new v&d minus old v&d.
  always_comb begin
    be_x = '0;
    v_x  = '0;
    d_x  = '0;
    wv_x = '0;
    wd_x = '0;
    be_x[SET_ASSOC-1:0] = sel_be;
    v_x[SET_ASSOC-1:0]  = cur_valid;
    d_x[SET_ASSOC-1:0]  = cur_dirty;
    wv_x[SET_ASSOC-1:0] = {SET_ASSOC{sel_v}};
    wd_x[SET_ASSOC-1:0] = {SET_ASSOC{sel_d}};
    pc_old     = popcount_vd(be_x, v_x, d_x);
    pc_new     = popcount_vd(be_x, wv_x, wd_x);
    delta      = signed'((CNT_W + 1)'(pc_new)) - signed'((CNT_W + 1)'(pc_old));
    count_next = signed'({1'b0, count_q}) + delta;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= SWEEP;
      ptr_q         <= '0;
      done_o        <= 1'b0;
      rvalid_o      <= 1'b0;
      valid_rdata_o <= '0;
      dirty_rdata_o <= '0;
      count_q       <= '0;
    end else begin
      state_q  <= state_d;
      done_o   <= (state_q == SWEEP) && (state_d == IDLE);
      rvalid_o <= gnt_any;
      if (sweep_start)          ptr_q <= '0;
      else if (state_q == SWEEP) ptr_q <= ptr_q + 1'b1;
      if (gnt_any) begin
        valid_rdata_o <= cur_valid;
        dirty_rdata_o <= cur_dirty;
      end
      if (sweep_start)  count_q <= '0;
      else if (wr_en)   count_q <= count_next[CNT_W-1:0];
      if (wr_en) assert (!count_next[CNT_W] && count_next <= MAX_CNT);
    end
  end

  // The array has no reset; the sweep that follows every reset clears it.
  always_ff @(posedge clk_i) begin
    if (state_q == SWEEP) begin
      arr_q[ptr_q] <= '0;
    end else if (wr_en) begin
      for (int w = 0; w < SET_ASSOC; w++) begin
        if (sel_be[w]) begin
          arr_q[sel_set][w].valid <= sel_v;
          arr_q[sel_set][w].dirty <= sel_d;
        end
      end
    end
  end

  assign busy_o        = (state_q == SWEEP);
  assign dirty_count_o = count_q;
  assign dirty_any_o   = (count_q != '0);
  assign state_o       = state_q;

endmodule

// File: tb/tb_nbdcache_vldrty_array.sv
// Bench for nbdcache_vldrty_array: directed walk of the main scenarios, then random traffic
// checked every cycle against an array-level reference model.
module tb_nbdcache_vldrty_array;
  import nbdcache_vldrty_pkg::*;

  localparam int NP = 4;
  localparam int NS = 256;
  localparam int SA = 8;
  localparam int IW = 8;
  localparam int CW = 12;

  logic              clk, rst;
  logic [NP-1:0]     req, gnt, we, vwd, dwd;
  logic [NP*IW-1:0]  set_bus;
  logic [NP*SA-1:0]  be_bus;
  logic              rvalid, inv, busy, done, dany, state_dbg;
  logic [SA-1:0]     vrd, drd;
  logic [CW-1:0]     cnt;

  int n_checks = 0;
  int n_fail   = 0;

  nbdcache_vldrty_array #(
    .NR_PORTS(NP), .NUM_SETS(NS), .SET_ASSOC(SA)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .we_i(we),
    .set_i(set_bus), .way_be_i(be_bus), .valid_wdata_i(vwd), .dirty_wdata_i(dwd),
    .rvalid_o(rvalid), .valid_rdata_o(vrd), .dirty_rdata_o(drd),
    .invalidate_i(inv), .busy_o(busy), .done_o(done),
    .dirty_count_o(cnt), .dirty_any_o(dany), .state_o(state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [SA-1:0]      m_v [NS];
  logic [SA-1:0]      m_d [NS];
  logic [2*SA-1:0]    exp_q[$];
  logic [2*SA-1:0]    m_last;
  bit                 m_busy, m_done, m_rvalid, chk_en;
  int                 m_left;

  function automatic int lowest_port(input logic [NP-1:0] r);
    for (int i = 0; i < NP; i++) if (r[i]) return i;
    return -1;
  endfunction

  function automatic int dirty_total();
    int t = 0;
    for (int s = 0; s < NS; s++) t += $countones(m_v[s] & m_d[s]);
    return t;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < NS; s++) begin
      m_v[s] = '0;
      m_d[s] = '0;
    end
  endtask

  always @(posedge clk) begin
    int p;
    logic [IW-1:0] s;
    logic [SA-1:0] be;
    if (rst) begin
      chk_en = 1;
      m_busy = 1; m_left = NS; m_done = 0; m_rvalid = 0; m_last = '0;
      exp_q.delete();
      model_clear();
    end else if (m_busy) begin
      m_rvalid = 0;
      m_done   = 0;
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end else begin
      m_done = 0;
      p = lowest_port(req);
      if (inv) begin
        m_busy = 1; m_left = NS; m_rvalid = 0;
        model_clear();
      end else if (p >= 0) begin
        s  = set_bus[p*IW +: IW];
        be = be_bus[p*SA +: SA];
        m_rvalid = 1;
        m_last   = {m_v[s], m_d[s]};
        exp_q.push_back(m_last);
        if (we[p]) begin
          m_v[s] = (m_v[s] & ~be) | (vwd[p] ? be : '0);
          m_d[s] = (m_d[s] & ~be) | (dwd[p] ? be : '0);
        end
      end else begin
        m_rvalid = 0;
      end
    end
  end

  // Per-cycle scoreboard compare, away from the active edge.
  always @(negedge clk) begin
    int p;
    logic [NP-1:0] eg;
    if (chk_en) begin
      p  = lowest_port(req);
      eg = (!m_busy && !inv && p >= 0) ? NP'(1 << p) : '0;
      check("gnt", gnt, eg);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("rvalid", rvalid, m_rvalid);
      check("count", cnt, dirty_total());
      check("dirty_any", dany, dirty_total() != 0);
      check("state", 32'(state_dbg), 32'(m_busy ? SWEEP : IDLE));
      if (m_rvalid) begin
        if (exp_q.size() == 0) check("exp_q_underflow", 1, 0);
        else check("rdata", {vrd, drd}, exp_q.pop_front());
      end else begin
        check("rdata_hold", {vrd, drd}, m_last);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; we = '0; set_bus = '0; be_bus = '0; vwd = '0; dwd = '0;
  endtask

  task automatic access(input int p, input bit w, input logic [IW-1:0] s,
                        input logic [SA-1:0] be, input bit v, input bit d);
    req[p] = 1'b1;
    we[p]  = w;
    set_bus[p*IW +: IW] = s;
    be_bus[p*SA +: SA]  = be;
    vwd[p] = v;
    dwd[p] = d;
  endtask

  // Counts cycles until the DUT drops busy; bounded so a stuck sweep still reaches the summary.
  task automatic wait_sweep(output int n);
    n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    if (busy) check("sweep_timeout", busy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1;
    inv = 1'b0;
    clear_inputs();
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 1);
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_done", done, 0);
    check("rst_count", cnt, 0);
    check("rst_rdata", {vrd, drd}, 0);

    wait_sweep(n);
    check("init_sweep_len", n, NS);
    check("init_done", done, 1);

    // Port 2 writes two dirty ways of set 5, then a read returns them.
    access(2, 1, 8'd5, 8'h0C, 1, 1);
    @(negedge clk);
    check("wr_gnt", gnt, 4'b0100);
    tick(); clear_inputs();
    check("wr_rvalid", rvalid, 1);
    check("wr_count", cnt, 2);
    access(0, 0, 8'd5, 8'h00, 0, 0);
    tick(); clear_inputs();
    check("rd_valid", vrd, 8'h0C);
    check("rd_dirty", drd, 8'h0C);

    // Priority: port 0 beats port 3, port 3 wins once port 0 drops.
    access(0, 0, 8'd7, 8'h00, 0, 0);
    access(3, 0, 8'd9, 8'h00, 0, 0);
    @(negedge clk);
    check("prio_gnt", gnt, 4'b0001);
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    check("hold_gnt", gnt, 4'b1000);
    tick(); clear_inputs();

    // Clean one way: read-before-write, then the new contents.
    access(1, 1, 8'd5, 8'h04, 1, 0);
    tick(); clear_inputs();
    check("rbw_dirty", drd, 8'h0C);
    check("rbw_count", cnt, 1);
    access(2, 0, 8'd5, 8'h00, 0, 0);
    tick(); clear_inputs();
    check("rd2_dirty", drd, 8'h08);
    check("rd2_valid", vrd, 8'h0C);

    // Empty-mask write is a legal no-op that still returns read data.
    access(3, 1, 8'd5, 8'h00, 1, 1);
    tick(); clear_inputs();
    check("noop_rvalid", rvalid, 1);
    check("noop_count", cnt, 1);

    // Invalidate beats a simultaneous request.
    inv = 1'b1;
    access(1, 0, 8'd5, 8'h00, 0, 0);
    @(negedge clk);
    check("inv_gnt", gnt, 0);
    tick(); inv = 1'b0; clear_inputs();
    check("inv_busy", busy, 1);
    check("inv_count", cnt, 0);
    check("inv_any", dany, 0);
    wait_sweep(n);
    check("inv_sweep_len", n, NS);
    access(0, 0, 8'd5, 8'h00, 0, 0);
    tick(); clear_inputs();
    check("post_inv_valid", vrd, 0);
    check("post_inv_dirty", drd, 0);

    // Reset at sweep pointer 100 restarts a full sweep.
    inv = 1'b1;
    tick(); inv = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
    check("rst_mid_done_lat", n, NS);

    // Random traffic with occasional invalidates.
    for (int c = 0; c < 1500; c++) begin
      inv = ($urandom_range(0, 299) == 0);
      req = NP'($urandom_range(0, 15));
      we  = NP'($urandom_range(0, 15));
      vwd = NP'($urandom_range(0, 15));
      dwd = NP'($urandom_range(0, 15));
      for (int p = 0; p < NP; p++) begin
        set_bus[p*IW +: IW] = ($urandom_range(0, 7) == 0) ? IW'($urandom_range(0, NS - 1))
                                                          : IW'($urandom_range(0, 3));
        be_bus[p*SA +: SA] = SA'($urandom_range(0, 255));
      end
      tick();
    end
    inv = 1'b0;
    clear_inputs();
    tick();
    wait_sweep(n);
    tick();

    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
